// File: rtl/cpu_2432_sram_resp.sv
// rtl/cpu_2432_sram_resp.sv - cpu_2432 data-port responder for a byte-wide async SRAM
// Splits each core load/store into per-lane SETUP/STROBE/HOLD cycles and stalls the core meanwhile.
module cpu_2432_sram_resp #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rstb,
  input  logic [23:0] i_daddr,
  input  logic        i_ram_rd,
  input  logic [3:0]  i_ram_wr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_clk_en,
  output logic [23:0] o_sram_addr,
  output logic [7:0]  o_sram_dout,
  output logic        o_sram_oe,
  input  logic [7:0]  i_sram_din,
  output logic        o_sram_ce_b,
  output logic        o_sram_oe_b,
  output logic        o_sram_we_b
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [3:0] WAIT_LAST = WAIT_CYCLES[3:0];

  state_t      state_q, state_d;
  logic [21:0] wadr_q, wadr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  rem_q, rem_d;
  logic [1:0]  lane_q, lane_d;
  logic        is_wr_q, is_wr_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        clk_en_q, clk_en_d;
  logic [23:0] sram_addr_q, sram_addr_d;
  logic [7:0]  sram_dout_q, sram_dout_d;
  logic        sram_oe_q, sram_oe_d;
  logic        ce_b_q, ce_b_d;
  logic        oe_b_q, oe_b_d;
  logic        we_b_q, we_b_d;
  logic [3:0]  lane_mask;

  // Byte-lane select of the word address is rebuilt from the lane counter.
  logic unused_daddr_lo;
  assign unused_daddr_lo = ^i_daddr[1:0];

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q     <= S_IDLE;
      wadr_q      <= '0;
      wdata_q     <= '0;
      rem_q       <= '0;
      lane_q      <= '0;
      is_wr_q     <= 1'b0;
      wait_q      <= '0;
      rdata_q     <= '0;
      clk_en_q    <= 1'b1;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      sram_oe_q   <= 1'b0;
      ce_b_q      <= 1'b1;
      oe_b_q      <= 1'b1;
      we_b_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      wadr_q      <= wadr_d;
      wdata_q     <= wdata_d;
      rem_q       <= rem_d;
      lane_q      <= lane_d;
      is_wr_q     <= is_wr_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      clk_en_q    <= clk_en_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      sram_oe_q   <= sram_oe_d;
      ce_b_q      <= ce_b_d;
      oe_b_q      <= oe_b_d;
      we_b_q      <= we_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wadr_d    = wadr_q;
    wdata_d   = wdata_q;
    rem_d     = rem_q;
    lane_d    = lane_q;
    is_wr_d   = is_wr_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    lane_mask = 4'h0;
    case (state_q)
      S_IDLE: begin
        if (i_ram_rd || (i_ram_wr != 4'h0)) begin
          is_wr_d   = (i_ram_wr != 4'h0);
          lane_mask = is_wr_d ? i_ram_wr : 4'hF;
          wadr_d    = i_daddr[23:2];
          wdata_d   = i_wdata;
          lane_d    = first_lane(lane_mask);
          rem_d     = lane_mask & ~(4'b0001 << lane_d);
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        wait_d  = 4'h0;
      end
      S_STROBE: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_HOLD;
          if (!is_wr_q) rdata_d[{lane_q, 3'b000} +: 8] = i_sram_din;
        end else begin
          wait_d = wait_q + 4'h1;
        end
      end
      S_HOLD: begin
        if (rem_q != 4'h0) begin
          lane_d  = first_lane(rem_q);
          rem_d   = rem_q & ~(4'b0001 << lane_d);
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are decoded from the next state so every output leaves a flop.
    clk_en_d    = (state_d == S_IDLE);
    ce_b_d      = (state_d == S_IDLE);
    oe_b_d      = !((state_d == S_STROBE) && !is_wr_d);
    we_b_d      = !((state_d == S_STROBE) && is_wr_d);
    sram_oe_d   = (state_d != S_IDLE) && is_wr_d;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    if (state_d == S_SETUP) begin
      sram_addr_d = {wadr_d, lane_d};
      if (is_wr_d) sram_dout_d = wdata_d[{lane_d, 3'b000} +: 8];
    end
  end

  assign o_rdata     = rdata_q;
  assign o_clk_en    = clk_en_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_dout = sram_dout_q;
  assign o_sram_oe   = sram_oe_q;
  assign o_sram_ce_b = ce_b_q;
  assign o_sram_oe_b = oe_b_q;
  assign o_sram_we_b = we_b_q;

endmodule

// File: tb/tb_cpu_2432_sram_resp.sv
// tb/tb_cpu_2432_sram_resp.sv - random and directed bench for cpu_2432_sram_resp
// Two instances (WAIT_CYCLES=1 and 0) share clock/reset; each has its own SRAM model.
module tb_cpu_2432_sram_resp;

  localparam int PMAX = 2048;

  logic        clk;
  logic        rstb;
  logic [23:0] daddr [2];
  logic        ram_rd [2];
  logic [3:0]  ram_wr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        clk_en [2];
  logic [23:0] sram_addr [2];
  logic [7:0]  sram_dout [2];
  logic        sram_oe [2];
  logic [7:0]  sram_din [2];
  logic        ce_b [2];
  logic        oe_b [2];
  logic        we_b [2];

  bit   [7:0]  sram_mem [2][4096];
  bit          sram_written [2][4096];
  logic [7:0]  ref_mem [2][4096];
  logic [31:0] last_rd [2];

  int          p_cnt [2];
  logic [23:0] p_addr [2][PMAX];
  logic [7:0]  p_data [2][PMAX];
  logic        p_rd [2][PMAX];
  int          p_width [2][PMAX];
  logic        prev_stb [2];
  logic [23:0] prev_addr [2];
  int          viol;

  int n_vec;
  int n_err;

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    if (a[11:2] == 10'h040) return 8'h11 * ({6'd0, a[1:0]} + 8'd1);
    return a[7:0] ^ {a[11:8], 4'h5};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : 0;
    cpu_2432_sram_resp #(.WAIT_CYCLES(WC)) u_dut (
      .i_clk       (clk),
      .i_rstb      (rstb),
      .i_daddr     (daddr[g]),
      .i_ram_rd    (ram_rd[g]),
      .i_ram_wr    (ram_wr[g]),
      .i_wdata     (wdata[g]),
      .o_rdata     (rdata[g]),
      .o_clk_en    (clk_en[g]),
      .o_sram_addr (sram_addr[g]),
      .o_sram_dout (sram_dout[g]),
      .o_sram_oe   (sram_oe[g]),
      .i_sram_din  (sram_din[g]),
      .o_sram_ce_b (ce_b[g]),
      .o_sram_oe_b (oe_b[g]),
      .o_sram_we_b (we_b[g])
    );
    assign sram_din[g] = (!ce_b[g] && !oe_b[g]) ?
      (sram_written[g][sram_addr[g][11:0]] ? sram_mem[g][sram_addr[g][11:0]]
                                           : init_byte(sram_addr[g][11:0])) : 8'h00;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor and SRAM write port: records each strobe pulse and flags protocol violations.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic stb;
      stb = !oe_b[d] || !we_b[d];
      if (!oe_b[d] && !we_b[d]) viol++;
      if (!oe_b[d] && sram_oe[d]) viol++;
      if (!we_b[d] && !sram_oe[d]) viol++;
      if (stb && ce_b[d]) viol++;
      if (stb && prev_stb[d]) begin
        if (sram_addr[d] != prev_addr[d]) viol++;
        if (p_cnt[d] > 0) p_width[d][p_cnt[d]-1]++;
      end else if (stb && p_cnt[d] < PMAX) begin
        p_addr[d][p_cnt[d]]  = sram_addr[d];
        p_data[d][p_cnt[d]]  = sram_dout[d];
        p_rd[d][p_cnt[d]]    = !oe_b[d];
        p_width[d][p_cnt[d]] = 1;
        p_cnt[d]++;
      end
      if (!we_b[d] && !ce_b[d]) begin
        sram_mem[d][sram_addr[d][11:0]]     = sram_dout[d];
        sram_written[d][sram_addr[d][11:0]] = 1'b1;
      end
      prev_stb[d]  = stb;
      prev_addr[d] = sram_addr[d];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle(input int d);
    daddr[d]  = '0;
    ram_rd[d] = 1'b0;
    ram_wr[d] = 4'h0;
    wdata[d]  = '0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where o_clk_en is back high.
  task automatic do_req(input int d, input logic [23:0] a, input logic rd,
                        input logic [3:0] w, input logic [31:0] wd);
    logic        is_wr;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    int          n, wc, start, stall, k;
    wc     = (d == 0) ? 1 : 0;
    is_wr  = (w != 4'h0);
    mask   = is_wr ? w : 4'hF;
    n      = $countones(mask);
    start  = p_cnt[d];
    daddr[d]  = a;
    ram_rd[d] = rd;
    ram_wr[d] = w;
    wdata[d]  = wd;
    @(posedge clk);
    stall = 0;
    @(negedge clk);
    while (clk_en[d] == 1'b0 && stall < 400) begin
      stall++;
      @(negedge clk);
    end
    drive_idle(d);
    chk("stall_cycles", stall, n * (wc + 3));
    chk("pulse_count", p_cnt[d] - start, n);
    k      = start;
    exp_rd = last_rd[d];
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        logic [11:0] ma;
        ma = {a[11:2], 2'(l)};
        chk("pulse_addr", p_addr[d][k], {a[23:2], 2'(l)});
        chk("pulse_width", p_width[d][k], wc + 1);
        chk("pulse_is_read", p_rd[d][k], !is_wr);
        if (is_wr) begin
          chk("pulse_wdata", p_data[d][k], wd[8*l +: 8]);
          ref_mem[d][ma] = wd[8*l +: 8];
        end else begin
          exp_rd[8*l +: 8] = ref_mem[d][ma];
        end
        k++;
      end
    end
    if (!is_wr) last_rd[d] = exp_rd;
    chk("rdata", rdata[d], last_rd[d]);
  endtask

  task automatic do_noop(input int d, input int cycles);
    int start, busy;
    start = p_cnt[d];
    busy  = 0;
    drive_idle(d);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (!clk_en[d] || !ce_b[d]) busy++;
    end
    chk("noop_busy", busy, 0);
    chk("noop_pulses", p_cnt[d] - start, 0);
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_clk_en", clk_en[d], 1'b1);
    chk("rst_ce_b", ce_b[d], 1'b1);
    chk("rst_oe_b", oe_b[d], 1'b1);
    chk("rst_we_b", we_b[d], 1'b1);
    chk("rst_sram_oe", sram_oe[d], 1'b0);
    chk("rst_rdata", rdata[d], 32'h0);
    chk("rst_addr", sram_addr[d], 24'h0);
    chk("rst_dout", sram_dout[d], 8'h0);
  endtask

  initial begin
    int start, to;
    n_vec = 0;
    n_err = 0;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 4096; a++) ref_mem[d][a] = init_byte(12'(a));
      last_rd[d] = '0;
      drive_idle(d);
    end
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rstb = 1'b1;
    @(negedge clk);

    // Directed cases, WAIT_CYCLES=1 instance.
    do_req(0, 24'h000102, 1'b1, 4'b0000, 32'h0);
    chk("word_read_value", rdata[0], 32'h44332211);
    do_req(0, 24'h000206, 1'b0, 4'b0100, 32'h00AB0000);
    chk("byte_store_keeps_rdata", rdata[0], 32'h44332211);
    do_req(0, 24'h000012, 1'b0, 4'b1100, 32'hBEEF0000);
    do_req(0, 24'h000010, 1'b1, 4'b0000, 32'h0);
    do_req(0, 24'h000300, 1'b1, 4'b0001, 32'h000000C3);
    do_noop(0, 4);

    // Reset in lane 1 STROBE of a read.
    start = p_cnt[0];
    daddr[0]  = 24'h000340;
    ram_rd[0] = 1'b1;
    @(posedge clk);
    to = 0;
    while ((p_cnt[0] - start) < 2 && to < 100) begin
      @(negedge clk);
      to++;
    end
    chk("rst_during_strobe", oe_b[0], 1'b0);
    rstb = 1'b0;
    drive_idle(0);
    #1;
    chk_reset_outputs(0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    do_req(0, 24'h000341, 1'b1, 4'b0000, 32'h0);

    // WAIT_CYCLES=0 instance: back-to-back word read then word store, then read-back.
    do_req(1, 24'h000400, 1'b1, 4'b0000, 32'h0);
    do_req(1, 24'h000400, 1'b0, 4'b1111, 32'hCAFEF00D);
    do_req(1, 24'h000400, 1'b1, 4'b0000, 32'h0);

    for (int t = 0; t < 80; t++) begin
      int          d, kind;
      logic [23:0] a;
      logic [3:0]  w;
      logic [31:0] wd;
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 4));
      a    = {12'($urandom), 6'd0, 6'($urandom)};
      w    = 4'($urandom_range(1, 15));
      wd   = $urandom;
      case (kind)
        0, 1: do_req(d, a, 1'b1, 4'b0000, wd);
        2:    do_req(d, a, 1'b0, w, wd);
        3:    do_req(d, a, 1'b1, w, wd);
        default: do_noop(d, int'($urandom_range(1, 3)));
      endcase
    end

    chk("protocol_violations", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
